// File: rtl/rf_wport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter_pkg
// Description : Shared widths, bus/entry layouts and helpers for the
//               register-file write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wport_arbiter_pkg;

    // Regfile write bus: {we, waddr, wdata}
    localparam int RF_WPORT_WD = 38;
    // Long-latency queue entry: {kill, waddr, wdata}
    localparam int LU_ENTRY_WD = 38;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_wport_bus_t;

    typedef struct packed {
        logic        kill;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } lu_entry_t;

    // One-hot of a GPR index; r0 is hard-wired so its bit never sets.
    function automatic logic [31:0] onehot_gpr(input logic [4:0] a);
        logic [31:0] v;
        v    = 32'd1 << a;
        v[0] = 1'b0;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wport_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter_if
// Description : WB, long-latency result and regfile write-port signals.
//               master = pipeline side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wport_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] lu_pending;
    logic        stall_req;

    modport master (
        output wb_we, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata,
        input  lu_ready, rf_we, rf_waddr, rf_wdata, lu_pending, stall_req
    );

    modport slave (
        input  wb_we, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata,
        output lu_ready, rf_we, rf_waddr, rf_wdata, lu_pending, stall_req
    );
endinterface
`default_nettype wire

// File: rtl/rf_wport_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_fifo
// Description : Long-latency result queue with per-entry kill bits and a
//               kill-by-address compare across all live entries.
//               Exposes the post-edge live mask/addresses for the pending mask.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_push,
    input  wire lu_entry_t            i_push_entry,
    input  wire logic                 i_pop,
    input  wire logic                 i_kill_en,
    input  wire logic [4:0]           i_kill_addr,
    output logic                      o_full,
    output logic                      o_empty,
    output lu_entry_t                 o_head,
    output logic [DEPTH-1:0]          o_live_nxt,
    output logic [DEPTH*5-1:0]        o_addr_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    lu_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;

    lu_entry_t        w_mem_nxt [DEPTH];
    logic [DEPTH-1:0] w_valid_nxt;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign o_head  = r_mem[w_rd_idx];

    // Next entry state: kill matching addresses, retire the head, write the tail.
    always_comb begin
        w_mem_nxt   = r_mem;
        w_valid_nxt = r_valid;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_kill_en && r_valid[i] && (r_mem[i].waddr == i_kill_addr)) begin
                w_mem_nxt[i].kill = 1'b1;
            end
        end
        if (i_pop) begin
            w_valid_nxt[w_rd_idx] = 1'b0;
        end
        if (i_push) begin
            w_mem_nxt[w_wr_idx]   = i_push_entry;
            w_valid_nxt[w_wr_idx] = 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_live
        assign o_live_nxt[g]       = w_valid_nxt[g] && !w_mem_nxt[g].kill;
        assign o_addr_nxt[g*5 +: 5] = w_mem_nxt[g].waddr;
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_mem   <= w_mem_nxt;
            r_valid <= w_valid_nxt;
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter
// Description : Shares the regfile write port between WB (absolute priority)
//               and queued long-latency results drained into idle WB cycles.
//               Drives the GPR pending mask and a starvation stall request.
//               Optional macro RF_WPORT_BYPASS_EN: a nonzero result accepted
//               into an empty queue while WB is idle is written directly.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    rf_wport_arbiter_if.slave    bus
);

    localparam logic [3:0] c_STARVE_LIM = 4'(STARVE_LIMIT);

    logic               w_full;
    logic               w_empty;
    lu_entry_t          w_head;
    logic [DEPTH-1:0]   w_live_nxt;
    logic [DEPTH*5-1:0] w_addr_nxt;
    logic               w_wb_write;
    logic               w_accept;
    logic               w_lu_live;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    lu_entry_t          w_push_entry;
    rf_wport_bus_t      w_rf;
    logic [31:0]        w_pending_nxt;
    logic [3:0]         w_starve_nxt;
    logic [3:0]         r_starve;
    logic [31:0]        r_pending;
    logic               r_stall;

    assign w_wb_write = bus.wb_we && (bus.wb_waddr != 5'd0);
    assign w_accept   = bus.lu_valid && !w_full;
    assign w_lu_live  = w_accept && (bus.lu_waddr != 5'd0);

`ifdef RF_WPORT_BYPASS_EN
    assign w_bypass = w_lu_live && w_empty && !w_wb_write;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_lu_live && !w_bypass;
    assign w_pop  = !w_wb_write && !w_empty;

    // Results are always older than WB, so a same-cycle WB write to the
    // same register supersedes the incoming result immediately.
    assign w_push_entry.kill  = w_wb_write && (bus.wb_waddr == bus.lu_waddr);
    assign w_push_entry.waddr = bus.lu_waddr;
    assign w_push_entry.wdata = bus.lu_wdata;

    rf_wport_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill_en    (w_wb_write),
        .i_kill_addr  (bus.wb_waddr),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head       (w_head),
        .o_live_nxt   (w_live_nxt),
        .o_addr_nxt   (w_addr_nxt)
    );

    // Write-port mux: WB first, then the queue head, then a bypassed result.
    always_comb begin
        w_rf = '0;
        if (w_wb_write) begin
            w_rf.we    = 1'b1;
            w_rf.waddr = bus.wb_waddr;
            w_rf.wdata = bus.wb_wdata;
        end else if (!w_empty) begin
            if (!w_head.kill) begin
                w_rf.we    = 1'b1;
                w_rf.waddr = w_head.waddr;
                w_rf.wdata = w_head.wdata;
            end
        end else if (w_bypass) begin
            w_rf.we    = 1'b1;
            w_rf.waddr = bus.lu_waddr;
            w_rf.wdata = bus.lu_wdata;
        end
    end

    // Pending mask as it will stand after this edge.
    always_comb begin
        w_pending_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live_nxt[i]) begin
                w_pending_nxt = w_pending_nxt | onehot_gpr(w_addr_nxt[i*5 +: 5]);
            end
        end
    end

    // Starvation count: head blocked by WB; cleared by a pop or an empty queue.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_empty || w_pop) begin
            w_starve_nxt = 4'd0;
        end else if (r_starve != c_STARVE_LIM) begin
            w_starve_nxt = r_starve + 4'd1;
        end
    end

    // Counter, pending mask and stall request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve  <= 4'd0;
            r_pending <= '0;
            r_stall   <= 1'b0;
        end else begin
            r_starve  <= w_starve_nxt;
            r_pending <= w_pending_nxt;
            if (w_empty || w_pop) begin
                r_stall <= 1'b0;
            end else if (w_starve_nxt == c_STARVE_LIM) begin
                r_stall <= 1'b1;
            end
        end
    end

    assign bus.lu_ready   = !w_full;
    assign bus.rf_we      = w_rf.we;
    assign bus.rf_waddr   = w_rf.waddr;
    assign bus.rf_wdata   = w_rf.wdata;
    assign bus.lu_pending = r_pending;
    assign bus.stall_req  = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wport_arbiter
// Description : Directed bench for rf_wport_arbiter (DEPTH=2, STARVE_LIMIT=4)
//               with a scoreboard of expected drained regfile writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wport_arbiter;
    import rf_wport_arbiter_pkg::*;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rf_wport_arbiter_if bus ();

    rf_wport_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        bus.wb_we    = wwe;
        bus.wb_waddr = wa;
        bus.wb_wdata = wd;
        bus.lu_valid = lv;
        bus.lu_waddr = la;
        bus.lu_wdata = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every cycle: WB writes must pass straight through; any other write must
    // be the oldest expected long-latency result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.wb_we && (bus.wb_waddr != 5'd0)) begin
                chk("wb_pass_we", 64'(bus.rf_we), 64'(1));
                chk("wb_pass", 64'({bus.rf_waddr, bus.rf_wdata}), 64'({bus.wb_waddr, bus.wb_wdata}));
            end else if (bus.rf_we) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_write: observed=%0h expected=none",
                           {bus.rf_waddr, bus.rf_wdata});
                end else begin
                    e = sb.pop_front();
                    chk("drain", 64'({bus.rf_waddr, bus.rf_wdata}), 64'({e.a, e.d}));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready",   64'(bus.lu_ready),   64'(1));
        chk("rst_pending", 64'(bus.lu_pending), 64'(0));
        chk("rst_rf_we",   64'(bus.rf_we),      64'(0));
        chk("rst_stall",   64'(bus.stall_req),  64'(0));
        tick();
        rst_n = 1'b1;

        // ---- idle drain: r8 = DEADBEEF
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEADBEEF);
        sb.push_back('{5'd8, 32'hDEADBEEF});
        @(negedge clk);
        chk("drain_ready", 64'(bus.lu_ready), 64'(1));
`ifdef RF_WPORT_BYPASS_EN
        chk("drain_acc_we", 64'(bus.rf_we), 64'(1));
`else
        chk("drain_acc_we", 64'(bus.rf_we), 64'(0));
`endif
        tick();
        idle();
        @(negedge clk);
`ifndef RF_WPORT_BYPASS_EN
        chk("drain_pending8", 64'(bus.lu_pending), 64'(32'h0000_0100));
        chk("drain_we", 64'(bus.rf_we), 64'(1));
`endif
        tick();
        @(negedge clk);
        chk("drain_pending_clr", 64'(bus.lu_pending), 64'(0));
        chk("drain_done_we", 64'(bus.rf_we), 64'(0));
        tick();

        // ---- priority/kill: queue r5=0x11 (WB busy on r30), then WB r5=0x22
        drive(1'b1, 5'd30, 32'h5555, 1'b1, 5'd5, 32'h11);
        tick();
        drive(1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("kill_pending5", 64'(bus.lu_pending), 64'(32'h0000_0020));
        tick();
        idle();
        @(negedge clk);
        chk("kill_pop_we", 64'(bus.rf_we), 64'(0));
        chk("kill_pending_clr", 64'(bus.lu_pending), 64'(0));
        tick();
        @(negedge clk);
        chk("kill_after_ready", 64'(bus.lu_ready), 64'(1));
        tick();

        // ---- kill on entry: lu r6 and WB r6 in the same cycle
        drive(1'b1, 5'd6, 32'h44, 1'b1, 5'd6, 32'h33);
        @(negedge clk);
        chk("kentry_ready", 64'(bus.lu_ready), 64'(1));
        tick();
        idle();
        @(negedge clk);
        chk("kentry_pending", 64'(bus.lu_pending), 64'(0));
        chk("kentry_we", 64'(bus.rf_we), 64'(0));
        tick();

        // ---- full: three results while WB busy
        drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd10, 32'h1010);
        sb.push_back('{5'd10, 32'h1010});
        @(negedge clk);
        chk("full_ready1", 64'(bus.lu_ready), 64'(1));
        tick();
        drive(1'b1, 5'd2, 32'hA2, 1'b1, 5'd11, 32'h1111);
        sb.push_back('{5'd11, 32'h1111});
        @(negedge clk);
        chk("full_ready2", 64'(bus.lu_ready), 64'(1));
        tick();
        drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd12, 32'h1212);
        @(negedge clk);
        chk("full_ready3", 64'(bus.lu_ready), 64'(0));
        chk("full_pending", 64'(bus.lu_pending), 64'(32'h0000_0C00));
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1212);
        @(negedge clk);
        chk("full_pop_ready", 64'(bus.lu_ready), 64'(0));
        chk("full_pop_we", 64'(bus.rf_we), 64'(1));
        tick();
        sb.push_back('{5'd12, 32'h1212});
        @(negedge clk);
        chk("full_acc_ready", 64'(bus.lu_ready), 64'(1));
        tick();
        idle();
        @(negedge clk);
        chk("full_last_we", 64'(bus.rf_we), 64'(1));
        tick();
        @(negedge clk);
        chk("full_end_we", 64'(bus.rf_we), 64'(0));
        chk("full_end_pending", 64'(bus.lu_pending), 64'(0));
        tick();

        // ---- starvation: r20 queued, WB writes r1..r9 back to back
        drive(1'b1, 5'd31, 32'h3131, 1'b1, 5'd20, 32'h2020);
        sb.push_back('{5'd20, 32'h2020});
        tick();
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 5'(k), 32'(k), 1'b0, 5'd0, 32'd0);
            @(negedge clk);
            chk($sformatf("starve_stall_c%0d", k), 64'(bus.stall_req), 64'(k >= 5));
            tick();
        end
        idle();
        @(negedge clk);
        chk("starve_pop_stall", 64'(bus.stall_req), 64'(1));
        chk("starve_pop_we", 64'(bus.rf_we), 64'(1));
        tick();
        @(negedge clk);
        chk("starve_drop", 64'(bus.stall_req), 64'(0));
        chk("starve_end_we", 64'(bus.rf_we), 64'(0));
        tick();

        // ---- r0 result: acknowledged, never written
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD);
        @(negedge clk);
        chk("r0_ready", 64'(bus.lu_ready), 64'(1));
        chk("r0_we", 64'(bus.rf_we), 64'(0));
        tick();
        idle();
        @(negedge clk);
        chk("r0_next_we", 64'(bus.rf_we), 64'(0));
        chk("r0_pending", 64'(bus.lu_pending), 64'(0));
        tick();

        // ---- r9 into empty queue with WB idle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_9999);
        sb.push_back('{5'd9, 32'h9999_9999});
        @(negedge clk);
`ifdef RF_WPORT_BYPASS_EN
        chk("byp_acc_we", 64'(bus.rf_we), 64'(1));
`else
        chk("byp_acc_we", 64'(bus.rf_we), 64'(0));
`endif
        tick();
        idle();
        @(negedge clk);
`ifdef RF_WPORT_BYPASS_EN
        chk("byp_next_we", 64'(bus.rf_we), 64'(0));
        chk("byp_pending", 64'(bus.lu_pending), 64'(0));
`else
        chk("byp_next_we", 64'(bus.rf_we), 64'(1));
        chk("byp_pending", 64'(bus.lu_pending), 64'(32'h0000_0200));
`endif
        tick();

        // ---- reset mid-drain: two entries queued behind WB
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'h1313);
        tick();
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd14, 32'h1414);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        chk("mrst_pending", 64'(bus.lu_pending), 64'(0));
        chk("mrst_rf_we", 64'(bus.rf_we), 64'(0));
        chk("mrst_ready", 64'(bus.lu_ready), 64'(1));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mrst_no_stale_%0d", k), 64'(bus.rf_we), 64'(0));
            tick();
        end

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
